// File: rtl/rmw_pkg.sv
// Shared op-code constants and FSM state encoding for the read-modify-write sequencer.
package rmw_pkg;

  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_DEC = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ASL = 4'd9;
  localparam logic [3:0] OP_LSR = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDummy,
    StWrite,
    StDone
  } rmw_state_e;

  function automatic logic op_is_valid(logic [3:0] op);
    return (op >= OP_INC) && (op <= OP_LSR);
  endfunction

  // INC/DEC leave the processor carry untouched.
  function automatic logic op_keeps_carry(logic [3:0] op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/rmw_sequencer.sv
// 6502-style read-modify-write sequencer: read, dummy write of the original value,
// write of the ALU result, then a one-cycle done/flags strobe. The ALU is external.
module rmw_sequencer
  import rmw_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  output logic              flags_we,
  output logic              n_out,
  output logic              z_out,
  output logic              c_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_carry_in,
  input  logic [8:0]        alu_f,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_carry
);

  rmw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        op_q, op_d;
  logic              cin_q, cin_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        res_q, res_d;
  logic              n_q, n_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  // The ninth ALU bit duplicates alu_carry; only the byte result is stored.
  logic unused_alu_f8;
  assign unused_alu_f8 = alu_f[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      data_q  <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      data_q  <= data_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    cin_d     = cin_q;
    data_d    = data_q;
    res_d     = res_q;
    n_d       = n_q;
    z_d       = z_q;
    c_d       = c_q;
    busy      = 1'b1;
    done      = 1'b0;
    flags_we  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start && op_is_valid(op)) begin
          addr_d  = addr;
          op_d    = op;
          cin_d   = c_in;
          state_d = StRead;
        end
      end
      StRead: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = StDummy;
        end
      end
      StDummy: begin
        mem_wr    = 1'b1;
        mem_wdata = data_q;
        if (mem_ready) begin
          res_d   = alu_f[7:0];
          n_d     = alu_negative;
          z_d     = alu_zero;
          c_d     = op_keeps_carry(op_q) ? cin_q : alu_carry;
          state_d = StWrite;
        end
      end
      StWrite: begin
        mem_wr    = 1'b1;
        mem_wdata = res_q;
        if (mem_ready) state_d = StDone;
      end
      StDone: begin
        done     = 1'b1;
        flags_we = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr     = addr_q;
  assign n_out        = n_q;
  assign z_out        = z_q;
  assign c_out        = c_q;
  assign alu_a        = data_q;
  assign alu_b        = data_q;
  assign alu_op       = op_q;
  assign alu_carry_in = cin_q;

endmodule

// File: tb/tb_rmw_sequencer.sv
// Scoreboard bench for rmw_sequencer: directed operations push expected memory and done
// events into a queue; a negedge monitor pops and compares whatever the DUT presents.
module tb_rmw_sequencer;
  import rmw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [15:0] addr;
  logic        c_in;
  logic        busy, done, flags_we, n_out, z_out, c_out;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_carry_in;
  logic [8:0]  alu_f;
  logic        alu_negative, alu_zero, alu_carry;

  rmw_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .c_in(c_in),
    .busy(busy), .done(done), .flags_we(flags_we),
    .n_out(n_out), .z_out(z_out), .c_out(c_out),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
    .alu_f(alu_f), .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU model.
  logic [7:0] alu_r;
  logic       alu_c;
  always_comb begin
    alu_r = alu_a;
    alu_c = 1'b0;
    case (alu_op)
      OP_INC: {alu_c, alu_r} = {1'b0, alu_a} + 9'd1;
      OP_DEC: {alu_c, alu_r} = {1'b0, alu_a} - 9'd1;
      OP_ROR: begin alu_r = {alu_carry_in, alu_a[7:1]}; alu_c = alu_a[0]; end
      OP_ROL: begin alu_r = {alu_a[6:0], alu_carry_in}; alu_c = alu_a[7]; end
      OP_ASL: begin alu_r = {alu_a[6:0], 1'b0};         alu_c = alu_a[7]; end
      OP_LSR: begin alu_r = {1'b0, alu_a[7:1]};         alu_c = alu_a[0]; end
      default: ;
    endcase
  end
  assign alu_f        = {alu_c, alu_r};
  assign alu_negative = alu_r[7];
  assign alu_zero     = (alu_r == 8'h00);
  assign alu_carry    = alu_c;

  // Memory model with per-phase stall configuration.
  logic [7:0] mem_val = 8'h00;
  int rd_cfg = 0, dm_cfg = 0, wr_cfg = 0;
  int rd_cnt = 0, wr_cnt = 0, wr_idx = 0;
  assign mem_rdata = mem_val;
  assign mem_ready = mem_rd ? (rd_cnt >= rd_cfg) :
                     mem_wr ? (wr_cnt >= ((wr_idx == 0) ? dm_cfg : wr_cfg)) : 1'b1;
  always @(posedge clk) begin
    if (!busy) begin
      rd_cnt <= 0; wr_cnt <= 0; wr_idx <= 0;
    end else begin
      if (mem_rd && !mem_ready) rd_cnt <= rd_cnt + 1;
      if (mem_wr && mem_ready) begin
        wr_idx <= wr_idx + 1; wr_cnt <= 0;
      end else if (mem_wr) begin
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  typedef struct {
    int          kind;  // 0 read, 1 write, 2 done
    logic [15:0] addr;
    logic [7:0]  data;
    logic        n, z, c;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0] op; logic [15:0] addr; logic [7:0] mem; logic cin;
    logic [7:0] res; logic n, z, c;
    int rd_st, dm_st, wr_st, lat; bit hold;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0;
  int   done_cnt = 0, start_cyc = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_expect(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    check(sb.size() != 0, "unexpected_event", kind, -1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.kind == kind, "event_kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: protocol checks and scoreboard comparison.
  logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n) begin
      check(!(mem_rd && mem_wr), "rd_wr_exclusive", {mem_rd, mem_wr}, 0);
      if (prev_stall) begin
        check({mem_rd, mem_wr} == {prev_rd, prev_wr}, "stall_strobes",
              {mem_rd, mem_wr}, {prev_rd, prev_wr});
        check(mem_addr == prev_addr, "stall_addr", mem_addr, prev_addr);
        check(mem_wdata == prev_wdata, "stall_wdata", mem_wdata, prev_wdata);
      end
      if (mem_rd && mem_ready) begin
        pop_expect(0, e, ok);
        if (ok) check(mem_addr == e.addr, "read_addr", mem_addr, e.addr);
      end
      if (mem_wr && mem_ready) begin
        pop_expect(1, e, ok);
        if (ok) begin
          check(mem_addr == e.addr, "write_addr", mem_addr, e.addr);
          check(mem_wdata == e.data, "write_data", mem_wdata, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        pop_expect(2, e, ok);
        if (ok) begin
          check(flags_we, "flags_we", flags_we, 1);
          check({n_out, z_out, c_out} == {e.n, e.z, e.c}, "flags_nzc",
                {n_out, z_out, c_out}, {e.n, e.z, e.c});
          check(cyc - start_cyc == e.lat, "latency", cyc - start_cyc, e.lat);
        end
      end
      if (flags_we && !done) check(1'b0 || done, "flags_we_without_done", flags_we, 0);
      prev_stall = (mem_rd || mem_wr) && !mem_ready;
      prev_rd    = mem_rd;
      prev_wr    = mem_wr;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_op(input vec_t v);
    bit seen;
    int base;
    rd_cfg = v.rd_st; dm_cfg = v.dm_st; wr_cfg = v.wr_st; mem_val = v.mem;
    sb.push_back('{kind: 0, addr: v.addr, data: v.mem, n: 0, z: 0, c: 0, lat: 0});
    sb.push_back('{kind: 1, addr: v.addr, data: v.mem, n: 0, z: 0, c: 0, lat: 0});
    sb.push_back('{kind: 1, addr: v.addr, data: v.res, n: 0, z: 0, c: 0, lat: 0});
    sb.push_back('{kind: 2, addr: v.addr, data: v.res, n: v.n, z: v.z, c: v.c, lat: v.lat});
    start = 1'b1; op = v.op; addr = v.addr; c_in = v.cin; start_cyc = cyc;
    @(posedge clk); #1;
    if (v.hold) begin
      addr = ~v.addr; op = OP_INC; c_in = ~v.cin;
    end else begin
      start = 1'b0;
    end
    seen = 1'b0;
    base = done_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base) begin seen = 1'b1; break; end
    end
    check(seen, "done_timeout", seen, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    bit seen;
    //           op      addr     mem    cin   res    n  z  c  rd dm wr lat hold
    vecs[0] = '{OP_ASL, 16'h0010, 8'h81, 1'b0, 8'h02, 0, 0, 1, 0, 0, 0, 4, 0};
    vecs[1] = '{OP_INC, 16'h1234, 8'hFF, 1'b0, 8'h00, 0, 1, 0, 0, 0, 0, 4, 1};
    vecs[2] = '{OP_ROR, 16'h0003, 8'h00, 1'b1, 8'h80, 1, 0, 0, 0, 0, 0, 4, 0};
    vecs[3] = '{OP_DEC, 16'hABCD, 8'h00, 1'b0, 8'hFF, 1, 0, 0, 0, 0, 0, 4, 0};
    vecs[4] = '{OP_ROL, 16'h00FF, 8'h80, 1'b1, 8'h01, 0, 0, 1, 3, 0, 2, 9, 0};
    vecs[5] = '{OP_LSR, 16'h8000, 8'h01, 1'b0, 8'h00, 0, 1, 1, 0, 0, 0, 4, 0};
    vecs[6] = '{OP_INC, 16'h0001, 8'h7F, 1'b1, 8'h80, 1, 0, 1, 0, 1, 0, 5, 0};

    rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({busy, done, flags_we, mem_rd, mem_wr} == 5'b0, "reset_ctrl",
          {busy, done, flags_we, mem_rd, mem_wr}, 0);
    check(mem_addr == 16'h0, "reset_mem_addr", mem_addr, 0);
    check(mem_wdata == 8'h0, "reset_mem_wdata", mem_wdata, 0);
    check({n_out, z_out, c_out} == 3'b0, "reset_flags", {n_out, z_out, c_out}, 0);
    check(alu_a == 8'h0 && alu_b == 8'h0, "reset_data_reg", {alu_a, alu_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Invalid op codes must be ignored.
    start = 1'b1; addr = 16'h0777; op = 4'd0;
    @(posedge clk); #1; op = 4'd11;
    @(posedge clk); #1; op = 4'd4;
    @(posedge clk); #1; start = 1'b0;
    check(!busy, "invalid_op_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check(!busy, "invalid_op_idle", busy, 0);

    // Reset during the dummy write abandons the operation.
    rd_cfg = 0; dm_cfg = 20; wr_cfg = 0; mem_val = 8'h55;
    sb.push_back('{kind: 0, addr: 16'h0042, data: 8'h55, n: 0, z: 0, c: 0, lat: 0});
    start = 1'b1; op = OP_ASL; addr = 16'h0042; c_in = 1'b0; start_cyc = cyc;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (mem_wr) begin seen = 1'b1; break; end
    end
    check(seen, "dummy_reached", seen, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check({busy, mem_wr, done, flags_we} == 4'b0, "midop_reset_ctrl",
          {busy, mem_wr, done, flags_we}, 0);
    check(mem_addr == 16'h0 && mem_wdata == 8'h0, "midop_reset_mem", {mem_addr, mem_wdata}, 0);
    check({n_out, z_out, c_out} == 3'b0, "midop_reset_flags", {n_out, z_out, c_out}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(!busy, "post_reset_idle", busy, 0);
    run_op('{OP_INC, 16'h0100, 8'h41, 1'b1, 8'h42, 0, 0, 1, 0, 0, 0, 4, 0});

    repeat (3) @(posedge clk);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rmw_sequencer.md
RMW_SEQUENCER -- requirements
Module: rmw_sequencer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, giving the memory address width.
REQ-002 The module SHALL have one clock, clk, and its reset SHALL be asynchronous and active-low, named rst_n.
REQ-003 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port start: input, 1 bit, request to run one read-modify-write operation.
REQ-006 Port op: input, 4 bits, ALU operation code. Only 5=INC, 6=DEC, 7=ROR, 8=ROL, 9=ASL and 10=LSR are valid.
REQ-007 Port addr: input, ADDR_W bits, operand address.
REQ-008 Port c_in: input, 1 bit, current processor carry flag.
REQ-009 Port busy: output, 1 bit, high while an operation is in progress.
REQ-010 Port done: output, 1 bit, one-cycle completion pulse.
REQ-011 Port flags_we: output, 1 bit, one-cycle strobe to update processor N, Z and C.
REQ-012 Ports n_out, z_out, c_out: outputs, 1 bit each, flag values to commit.
REQ-013 Ports mem_addr (ADDR_W bits), mem_rd (1 bit), mem_wr (1 bit) and mem_wdata (8 bits): outputs, the memory request.
REQ-014 Ports mem_rdata (8 bits) and mem_ready (1 bit): inputs, read data and request acknowledge.
REQ-015 Ports alu_a (8 bits), alu_b (8 bits), alu_op (4 bits) and alu_carry_in (1 bit): outputs that drive the external ALU.
REQ-016 Ports alu_f (9 bits), alu_negative, alu_zero and alu_carry (1 bit each): inputs, the ALU's combinational result and flags.

Function
REQ-017 The FSM SHALL have five states: IDLE, READ, DUMMY, WRITE and DONE.
REQ-018 In IDLE, start=1 with a valid op SHALL latch addr, op and c_in and move to READ on the next edge.
REQ-019 In IDLE, start=1 with an invalid op SHALL be ignored: the FSM stays in IDLE and no done pulse is produced.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 In READ, mem_rd=1 and mem_addr=latched address. On the cycle mem_ready=1, mem_rdata SHALL be captured into the data register and the FSM SHALL move to DUMMY.
REQ-022 In DUMMY, mem_wr=1 and mem_wdata=captured original data (6502 dummy write). On mem_ready=1, alu_f[7:0], alu_negative, alu_zero and alu_carry SHALL be captured into the result register and the FSM SHALL move to WRITE.
REQ-023 In WRITE, mem_wr=1 and mem_wdata=result register. On mem_ready=1 the FSM SHALL move to DONE.
REQ-024 In DONE, done=1 and flags_we=1 for exactly one cycle, then the FSM SHALL return to IDLE; a start during DONE is ignored.
REQ-025 alu_a and alu_b SHALL both equal the data register, alu_op SHALL equal the latched op, and alu_carry_in SHALL equal the latched c_in, at all times.
REQ-026 For ROR/ROL/ASL/LSR, c_out SHALL be the captured alu_carry.
REQ-027 For INC/DEC, c_out SHALL be the latched c_in (carry unchanged).
REQ-028 n_out and z_out SHALL be the captured flags; they are valid while flags_we=1 and hold until the next capture.
REQ-029 mem_rd and mem_wr SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.
REQ-030 mem_addr SHALL hold the latched address from READ through WRITE, so a stalled request (mem_ready=0) holds address, strobes and data stable for any number of cycles.
REQ-031 busy SHALL be 1 in READ, DUMMY, WRITE and DONE, and 0 in IDLE.
REQ-032 Minimum latency SHALL be 4 cycles from the start edge to done, when mem_ready=1 throughout.

Reset
REQ-033 While rst_n=0, the FSM SHALL be in IDLE and busy, done, flags_we, mem_rd and mem_wr SHALL all be 0.
REQ-034 While rst_n=0, mem_addr, mem_wdata, the data and result registers, n_out, z_out and c_out SHALL all be 0.
REQ-035 Reset asserted mid-operation SHALL abandon the operation immediately, with no done pulse and no flags_we pulse; the partial write is not retried.

Structure
REQ-036 Package rmw_pkg SHALL hold the op-code constants (OP_INC..OP_LSR) and the FSM state enum, shared with the core decode.
REQ-037 No sub-module: the ALU stays external at core top level so it can be shared with the main datapath.

Verification
REQ-038 ASL at 0x0010, mem=0x81, mem_ready=1 -> write 0x81 then write 0x02; n_out=0, z_out=0, c_out=1; done at cycle 4.
REQ-039 INC, mem=0xFF, c_in=0 -> write 0xFF then write 0x00; z_out=1, n_out=0, c_out=0.
REQ-040 ROR, mem=0x00, c_in=1 -> final write 0x80; n_out=1, c_out=0.
REQ-041 mem_ready held low 3 cycles in READ and 2 cycles in WRITE -> strobes, address and data stable throughout; done at cycle 9.
REQ-042 rst_n pulsed low during DUMMY -> IDLE immediately, mem_wr=0, no done or flags_we pulse; a following operation completes normally.
REQ-043 start with op=0, and start asserted while busy -> no memory activity and no extra done pulse.
